ysyx_22051013_wb_writer: RTL and testbench

// - Write-back queue driving the register file write port: collects results from the LSU and ALU producers,

---
 rtl/ysyx_22051013_wb_writer_if.sv | 53 +++++
 rtl/ysyx_22051013_wb_writer.sv | 123 ++++++++++++
 tb/tb_ysyx_22051013_wb_writer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22051013_wb_writer_if.sv
// ============================================================================
//  Module   : ysyx_22051013_wb_writer_if
//  Brief    : Producer, register-file and bypass signals of the write-back queue.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface ysyx_22051013_wb_writer_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [4:0]        lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic              alu_valid;
    logic              alu_ready;
    logic [4:0]        alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              wen;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic [c_CNT_W-1:0] count;
    logic              empty;
    logic [4:0]        byp_raddr1;
    logic              byp_hit1;
    logic [DATA_W-1:0] byp_data1;
    logic [4:0]        byp_raddr2;
    logic              byp_hit2;
    logic [DATA_W-1:0] byp_data2;

    modport master (
        output lsu_valid, lsu_rd, lsu_data,
        output alu_valid, alu_rd, alu_data,
        output byp_raddr1, byp_raddr2,
        input  lsu_ready, alu_ready,
        input  wen, waddr, wdata, count, empty,
        input  byp_hit1, byp_data1, byp_hit2, byp_data2
    );

    modport slave (
        input  lsu_valid, lsu_rd, lsu_data,
        input  alu_valid, alu_rd, alu_data,
        input  byp_raddr1, byp_raddr2,
        output lsu_ready, alu_ready,
        output wen, waddr, wdata, count, empty,
        output byp_hit1, byp_data1, byp_hit2, byp_data2
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_22051013_wb_writer.sv
// ============================================================================
//  Module   : ysyx_22051013_wb_writer
//  Brief    : In-order write-back queue (LSU + ALU producers) retiring one
//             register write per cycle. Optional bypass lookup: WB_BYPASS_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_22051013_wb_writer #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_22051013_wb_writer_if.slave      wb
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [4:0]         r_rd   [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic [c_CNT_W-1:0] w_free;
    logic               w_lsu_ready;
    logic               w_alu_ready;
    logic               w_lsu_push;
    logic               w_alu_push;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_alu_slot;

    // Credit comes only from the registered count, so a same-cycle pop never
    // lets an extra entry in.
    assign w_free      = c_CNT_W'(DEPTH) - r_count;
    assign w_lsu_ready = (w_free >= c_CNT_W'(1));
    assign w_alu_ready = (w_free >= c_CNT_W'(2)) ||
                         ((w_free >= c_CNT_W'(1)) && !wb.lsu_valid);

    // rd == 0 results complete the handshake but are never stored.
    assign w_lsu_push  = wb.lsu_valid && w_lsu_ready && (wb.lsu_rd != 5'd0);
    assign w_alu_push  = wb.alu_valid && w_alu_ready && (wb.alu_rd != 5'd0);
    assign w_pop       = (r_count != '0);
    assign w_alu_slot  = w_lsu_push ? (r_tail + c_PTR_W'(1)) : r_tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            r_tail  <= r_tail + c_PTR_W'(w_lsu_push) + c_PTR_W'(w_alu_push);
            r_count <= r_count + c_CNT_W'(w_lsu_push) + c_CNT_W'(w_alu_push)
                       - c_CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: only slots inside [head, head+count) are ever read.
    always_ff @(posedge clk) begin
        if (w_lsu_push) begin
            r_rd[r_tail]   <= wb.lsu_rd;
            r_data[r_tail] <= wb.lsu_data;
        end
        if (w_alu_push) begin
            r_rd[w_alu_slot]   <= wb.alu_rd;
            r_data[w_alu_slot] <= wb.alu_data;
        end
    end

    assign wb.lsu_ready = w_lsu_ready;
    assign wb.alu_ready = w_alu_ready;
    assign wb.wen       = w_pop;
    assign wb.waddr     = w_pop ? r_rd[r_head]   : 5'd0;
    assign wb.wdata     = w_pop ? r_data[r_head] : '0;
    assign wb.count     = r_count;
    assign wb.empty     = (r_count == '0);

`ifdef WB_BYPASS_EN
    for (genvar k = 0; k < 2; k++) begin : g_byp_port
        logic [4:0]        w_raddr;
        logic              w_hit;
        logic [DATA_W-1:0] w_data;

        assign w_raddr = (k == 0) ? wb.byp_raddr1 : wb.byp_raddr2;

        // Scan oldest to youngest so the youngest match wins.
        always_comb begin
            logic [c_PTR_W-1:0] v_idx;
            w_hit  = 1'b0;
            w_data = '0;
            v_idx  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                v_idx = r_head + c_PTR_W'(i);
                if ((c_CNT_W'(i) < r_count) && (w_raddr != 5'd0) &&
                    (r_rd[v_idx] == w_raddr)) begin
                    w_hit  = 1'b1;
                    w_data = r_data[v_idx];
                end
            end
        end
    end

    assign wb.byp_hit1  = g_byp_port[0].w_hit;
    assign wb.byp_data1 = g_byp_port[0].w_data;
    assign wb.byp_hit2  = g_byp_port[1].w_hit;
    assign wb.byp_data2 = g_byp_port[1].w_data;
`else
    logic w_unused_byp;
    assign w_unused_byp = ^{wb.byp_raddr1, wb.byp_raddr2};

    assign wb.byp_hit1  = 1'b0;
    assign wb.byp_data1 = '0;
    assign wb.byp_hit2  = 1'b0;
    assign wb.byp_data2 = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22051013_wb_writer.sv
// ============================================================================
//  Module   : tb_ysyx_22051013_wb_writer
//  Brief    : Directed and randomized checks of the write-back queue against
//             a queue-based reference model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ysyx_22051013_wb_writer;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22051013_wb_writer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
    ysyx_22051013_wb_writer_if #(.DATA_W(DATA_W), .DEPTH(2))     bus2 ();

    ysyx_22051013_wb_writer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk), .rst (rst), .wb (bus.slave));
    ysyx_22051013_wb_writer #(.DATA_W(DATA_W), .DEPTH(2)) dut2 (
        .clk (clk), .rst (rst), .wb (bus2.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the queued register writes, oldest first.
    logic [4:0]        q_rd   [$];
    logic [DATA_W-1:0] q_data [$];

    function automatic int m_free();
        return DEPTH - q_rd.size();
    endfunction

    function automatic logic m_lsu_ready();
        return m_free() >= 1;
    endfunction

    function automatic logic m_alu_ready(input logic lv);
        return (m_free() >= 2) || (m_free() >= 1 && !lv);
    endfunction

    function automatic void m_byp(input logic [4:0] a, output logic hit,
                                  output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (BYP && a != 5'd0)
            foreach (q_rd[i])
                if (q_rd[i] == a) begin
                    hit = 1'b1;
                    d   = q_data[i];
                end
    endfunction

    task automatic drive(input logic lv, input logic [4:0] lrd, input logic [DATA_W-1:0] ld,
                         input logic av, input logic [4:0] ard, input logic [DATA_W-1:0] ad);
        bus.lsu_valid = lv; bus.lsu_rd = lrd; bus.lsu_data = ld;
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    endtask

    task automatic drive2(input logic lv, input logic [4:0] lrd, input logic [DATA_W-1:0] ld,
                          input logic av, input logic [4:0] ard, input logic [DATA_W-1:0] ad);
        bus2.lsu_valid = lv; bus2.lsu_rd = lrd; bus2.lsu_data = ld;
        bus2.alu_valid = av; bus2.alu_rd = ard; bus2.alu_data = ad;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        logic lf, af;
        @(posedge clk);
        lf = bus.lsu_valid && m_lsu_ready();
        af = bus.alu_valid && m_alu_ready(bus.lsu_valid);
        if (rst) begin
            q_rd.delete();
            q_data.delete();
        end else begin
            if (q_rd.size() > 0) begin
                void'(q_rd.pop_front());
                void'(q_data.pop_front());
            end
            if (lf && bus.lsu_rd != 5'd0) begin
                q_rd.push_back(bus.lsu_rd); q_data.push_back(bus.lsu_data);
            end
            if (af && bus.alu_rd != 5'd0) begin
                q_rd.push_back(bus.alu_rd); q_data.push_back(bus.alu_data);
            end
        end
        #1;
    endtask

    task automatic flush();
        drive(0, 0, 0, 0, 0, 0);
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive2(0, 0, 0, 0, 0, 0);
        bus.byp_raddr1 = 5'd0; bus.byp_raddr2 = 5'd0;
        bus2.byp_raddr1 = 5'd0; bus2.byp_raddr2 = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        bus.byp_raddr1 = 5'd5;
        @(negedge clk);
        n_tests++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        n_tests++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got=%b exp=0", bus.wen); end
        n_tests++; if (bus.waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr got=%0d exp=0", bus.waddr); end
        n_tests++; if (bus.wdata !== '0) begin n_fail++; $display("FAIL reset_wdata got=%0h exp=0", bus.wdata); end
        n_tests++; if (bus.byp_hit1 !== 1'b0) begin n_fail++; $display("FAIL reset_byp_hit1 got=%b exp=0", bus.byp_hit1); end
        n_tests++; if (bus2.count !== 2'd0) begin n_fail++; $display("FAIL reset_count_d2 got=%0d exp=0", bus2.count); end
        bus.byp_raddr1 = 5'd0;
        tick();
    endtask

    task automatic test_single();
        drive(1, 5'd5, 64'hAA, 0, 0, 0);
        @(negedge clk);
        n_tests++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b exp=1", bus.lsu_ready); end
        n_tests++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL single_no_early_wen got=%b exp=0", bus.wen); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_tests++; if ({bus.wen, bus.waddr} !== {1'b1, 5'd5}) begin n_fail++; $display("FAIL single_write got wen=%b waddr=%0d exp wen=1 waddr=5", bus.wen, bus.waddr); end
        n_tests++; if (bus.wdata !== 64'hAA) begin n_fail++; $display("FAIL single_wdata got=%0h exp=aa", bus.wdata); end
        tick();
        @(negedge clk);
        n_tests++; if ({bus.empty, bus.wen} !== 2'b10) begin n_fail++; $display("FAIL single_after got empty=%b wen=%b exp empty=1 wen=0", bus.empty, bus.wen); end
        tick();
    endtask

    task automatic test_dual();
        flush();
        drive(1, 5'd3, 64'h11, 1, 5'd4, 64'h22);
        @(negedge clk);
        n_tests++; if ({bus.lsu_ready, bus.alu_ready} !== 2'b11) begin n_fail++; $display("FAIL dual_ready got lsu=%b alu=%b exp 1 1", bus.lsu_ready, bus.alu_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_tests++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b1, 5'd3, 64'h11}) begin n_fail++; $display("FAIL dual_first got waddr=%0d wdata=%0h exp 3 11", bus.waddr, bus.wdata); end
        tick();
        @(negedge clk);
        n_tests++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b1, 5'd4, 64'h22}) begin n_fail++; $display("FAIL dual_second got waddr=%0d wdata=%0h exp 4 22", bus.waddr, bus.wdata); end
        tick();
    endtask

    task automatic test_saturate();
        flush();
        for (int c = 0; c < 5; c++) begin
            drive(1, 5'(1 + c), 64'(c), 1, 5'(10 + c), 64'(100 + c));
            @(negedge clk);
            if (c >= 2) begin
                n_tests++; if ({bus.lsu_ready, bus.alu_ready} !== 2'b10) begin n_fail++; $display("FAIL sat_ready c=%0d got lsu=%b alu=%b exp 1 0", c, bus.lsu_ready, bus.alu_ready); end
                n_tests++; if ({bus.wen, bus.count} !== {1'b1, CW'(3)}) begin n_fail++; $display("FAIL sat_drain c=%0d got wen=%b count=%0d exp 1 3", c, bus.wen, bus.count); end
            end
            tick();
        end
        flush();
    endtask

    task automatic test_full_depth2();
        drive2(1, 5'd1, 64'h10, 1, 5'd2, 64'h20);
        @(negedge clk);
        n_tests++; if ({bus2.lsu_ready, bus2.alu_ready} !== 2'b11) begin n_fail++; $display("FAIL full_accept got lsu=%b alu=%b exp 1 1", bus2.lsu_ready, bus2.alu_ready); end
        tick();
        @(negedge clk);
        n_tests++; if ({bus2.lsu_ready, bus2.alu_ready, bus2.count} !== {2'b00, 2'd2}) begin n_fail++; $display("FAIL full_ready got lsu=%b alu=%b count=%0d exp 0 0 2", bus2.lsu_ready, bus2.alu_ready, bus2.count); end
        n_tests++; if ({bus2.wen, bus2.waddr, bus2.wdata} !== {1'b1, 5'd1, 64'h10}) begin n_fail++; $display("FAIL full_drain got wen=%b waddr=%0d wdata=%0h exp 1 1 10", bus2.wen, bus2.waddr, bus2.wdata); end
        tick();
        @(negedge clk);
        n_tests++; if ({bus2.count, bus2.lsu_ready, bus2.alu_ready, bus2.waddr} !== {2'd1, 2'b10, 5'd2}) begin n_fail++; $display("FAIL full_after got count=%0d lsu=%b alu=%b waddr=%0d exp 1 1 0 2", bus2.count, bus2.lsu_ready, bus2.alu_ready, bus2.waddr); end
        drive2(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_rd0();
        flush();
        drive(0, 0, 0, 1, 5'd0, 64'hFF);
        @(negedge clk);
        n_tests++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_ready got=%b exp=1", bus.alu_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_tests++; if ({bus.count, bus.wen} !== {CW'(0), 1'b0}) begin n_fail++; $display("FAIL rd0_nowrite got count=%0d wen=%b exp 0 0", bus.count, bus.wen); end
        tick();
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] e1, e2;
        flush();
        drive(1, 5'd7, 64'h1, 1, 5'd7, 64'h2);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        bus.byp_raddr1 = 5'd7; bus.byp_raddr2 = 5'd0;
        e1 = BYP ? 64'h2 : 64'h0;
        @(negedge clk);
        n_tests++; if ({bus.byp_hit1, bus.byp_data1} !== {BYP, e1}) begin n_fail++; $display("FAIL byp_youngest got hit=%b data=%0h exp hit=%b data=%0h", bus.byp_hit1, bus.byp_data1, BYP, e1); end
        n_tests++; if ({bus.byp_hit2, bus.byp_data2} !== {1'b0, 64'h0}) begin n_fail++; $display("FAIL byp_x0 got hit=%b data=%0h exp 0 0", bus.byp_hit2, bus.byp_data2); end
        tick();
        bus.byp_raddr1 = 5'd5; bus.byp_raddr2 = 5'd7;
        e2 = BYP ? 64'h2 : 64'h0;
        @(negedge clk);
        n_tests++; if ({bus.byp_hit2, bus.byp_data2, bus.byp_hit1} !== {BYP, e2, 1'b0}) begin n_fail++; $display("FAIL byp_head got hit2=%b data2=%0h hit1=%b exp %b %0h 0", bus.byp_hit2, bus.byp_data2, bus.byp_hit1, BYP, e2); end
        tick();
        bus.byp_raddr1 = 5'd0; bus.byp_raddr2 = 5'd0;
    endtask

    task automatic test_reset_middrain();
        flush();
        drive(1, 5'd1, 64'hA, 1, 5'd2, 64'hB);
        tick();
        drive(1, 5'd3, 64'hC, 1, 5'd4, 64'hD);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.count !== CW'(3)) begin n_fail++; $display("FAIL rstmid_pre got count=%0d exp 3", bus.count); end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++; if ({bus.count, bus.wen, bus.empty} !== {CW'(0), 2'b01}) begin n_fail++; $display("FAIL rstmid_post c=%0d got count=%0d wen=%b exp 0 0", c, bus.count, bus.wen); end
            tick();
        end
    endtask

    task automatic test_random();
        logic e_h1, e_h2;
        logic [DATA_W-1:0] e_d1, e_d2;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), {$urandom, $urandom});
            bus.byp_raddr1 = 5'($urandom_range(0, 7));
            bus.byp_raddr2 = 5'($urandom_range(0, 7));
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            m_byp(bus.byp_raddr1, e_h1, e_d1);
            m_byp(bus.byp_raddr2, e_h2, e_d2);
            n_tests++; if (bus.lsu_ready !== m_lsu_ready()) begin n_fail++; $display("FAIL rand_lsu_ready c=%0d got=%b exp=%b", c, bus.lsu_ready, m_lsu_ready()); end
            n_tests++; if (bus.alu_ready !== m_alu_ready(bus.lsu_valid)) begin n_fail++; $display("FAIL rand_alu_ready c=%0d got=%b exp=%b", c, bus.alu_ready, m_alu_ready(bus.lsu_valid)); end
            n_tests++; if (bus.count !== CW'(q_rd.size())) begin n_fail++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, bus.count, q_rd.size()); end
            n_tests++; if (bus.empty !== (q_rd.size() == 0)) begin n_fail++; $display("FAIL rand_empty c=%0d got=%b exp=%b", c, bus.empty, q_rd.size() == 0); end
            n_tests++; if (bus.wen !== (q_rd.size() != 0)) begin n_fail++; $display("FAIL rand_wen c=%0d got=%b exp=%b", c, bus.wen, q_rd.size() != 0); end
            if (q_rd.size() != 0) begin
                n_tests++; if ({bus.waddr, bus.wdata} !== {q_rd[0], q_data[0]}) begin n_fail++; $display("FAIL rand_write c=%0d got waddr=%0d wdata=%0h exp %0d %0h", c, bus.waddr, bus.wdata, q_rd[0], q_data[0]); end
            end else begin
                n_tests++; if ({bus.waddr, bus.wdata} !== '0) begin n_fail++; $display("FAIL rand_idle_write c=%0d got waddr=%0d wdata=%0h exp 0 0", c, bus.waddr, bus.wdata); end
            end
            n_tests++; if ({bus.byp_hit1, bus.byp_data1} !== {e_h1, e_d1}) begin n_fail++; $display("FAIL rand_byp1 c=%0d got hit=%b data=%0h exp %b %0h", c, bus.byp_hit1, bus.byp_data1, e_h1, e_d1); end
            n_tests++; if ({bus.byp_hit2, bus.byp_data2} !== {e_h2, e_d2}) begin n_fail++; $display("FAIL rand_byp2 c=%0d got hit=%b data=%0h exp %b %0h", c, bus.byp_hit2, bus.byp_data2, e_h2, e_d2); end
            tick();
        end
        rst = 1'b0;
        bus.byp_raddr1 = 5'd0; bus.byp_raddr2 = 5'd0;
        flush();
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_saturate();
        test_full_depth2();
        test_rd0();
        test_bypass();
        test_reset_middrain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
